// File: rtl/aes_sbox.sv
// aes_sbox: registered AES forward substitution box (FIPS-197 SubBytes).
//
// The substitution is computed combinationally as the GF(2^8) multiplicative
// inverse modulo x^8+x^4+x^3+x+1 (0 maps to 0), followed by the affine
// transform with constant 0x63. The result is captured in dout_q on every
// valid cycle. dout_q is the only state, and it drives dout directly.
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     synchronous, active-high reset; clears dout to 8'h00
//   valid_in  qualifies addr for the current cycle
//   addr      byte to be substituted
//   dout      registered S-box output, one cycle after a valid addr
module aes_sbox (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] addr,
  output logic [7:0] dout
);

  // Multiply by x, then reduce modulo the AES polynomial.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end
      sh = gf_xtime(sh);
    end
    gf_mul = acc;
  endfunction

  // Inverse as a^254, which is a^-1 for a != 0 and 0 for a == 0.
  // Addition chain: 2, 3, 6, 12, 15, 30, 60, 120, 240, 252, 254.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] a12;
    logic [7:0] a15;
    logic [7:0] a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(a3, a3);
    a12  = gf_mul(a12, a12);
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    gf_inv = gf_mul(gf_mul(a240, a12), a2);
  endfunction

  // b[i] = a[i] ^ a[i+4] ^ a[i+5] ^ a[i+6] ^ a[i+7] ^ c[i], indices mod 8.
  function automatic logic [7:0] affine(input logic [7:0] a);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8]
           ^ a[(i + 7) % 8] ^ c[i];
    end
    affine = b;
  endfunction

  logic [7:0] sbox_val;
  logic [7:0] dout_q;

  always_comb begin
    sbox_val = affine(gf_inv(addr));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= 8'h00;
    end else if (valid_in) begin
      dout_q <= sbox_val;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_aes_sbox.sv
// tb_aes_sbox: scoreboard bench for aes_sbox.
// The driver applies inputs on the falling edge and pushes the expected dout
// for the following rising edge. The monitor pops one entry after each rising
// edge and compares it with dout.
module tb_aes_sbox;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic [7:0] addr;
  logic [7:0] dout;

  aes_sbox dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .addr     (addr),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] a;
    int         tag;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks;
  int         n_fail;
  logic [7:0] sbox_tab[256];
  logic [7:0] model_q;
  bit         seen_reset;

  string tag_names[7] = '{"reset", "sweep", "refpoint", "hold", "b2b", "midreset", "random"};

  // Carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] poly;
    p = 15'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      poly = 15'h11b;
      if (p[i]) p = p ^ (poly << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Inverse by exhaustive search, then the rotate-form affine transform.
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] xb;
      inv = 8'h00;
      xb  = 8'(x);
      for (int y = 1; y < 256; y++) begin
        if (ref_mul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  // One cycle of stimulus. If override is set, exp_const replaces the model
  // value, so the spec's reference points are checked independently.
  task automatic step(input logic r, input logic v, input logic [7:0] a, input int tag,
                      input bit override = 0, input logic [7:0] exp_const = 8'h00);
    exp_t e;
    @(negedge clk);
    reset    = r;
    valid_in = v;
    addr     = a;
    if (r) begin
      model_q    = 8'h00;
      seen_reset = 1'b1;
    end else if (v) begin
      model_q = sbox_tab[a];
    end
    if (seen_reset) begin
      e.exp = override ? exp_const : model_q;
      e.a   = a;
      e.tag = tag;
      sb_q.push_back(e);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (dout !== e.exp) begin
          n_fail++;
          $display("FAIL %s: addr=%02h dout=%02h expected=%02h", tag_names[e.tag], e.a, dout,
                   e.exp);
        end
      end
    end
  end

  logic [7:0] ref_in[9]  = '{8'h00, 8'h01, 8'h0f, 8'h10, 8'h20, 8'h53, 8'h80, 8'hc9, 8'hff};
  logic [7:0] ref_out[9] = '{8'h63, 8'h7c, 8'h76, 8'hca, 8'hb7, 8'hed, 8'hcd, 8'hdd, 8'h16};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    seen_reset = 1'b0;
    model_q    = 8'h00;
    reset      = 1'b0;
    valid_in   = 1'b0;
    addr       = 8'h00;
    #1;

    // Reset held three cycles with a valid byte present, then release.
    repeat (3) step(1'b1, 1'b1, 8'h53, 0, 1, 8'h00);
    step(1'b0, 1'b1, 8'h53, 0, 1, 8'hed);

    // Exhaustive sweep against the reference model.
    for (int i = 0; i < 256; i++) step(1'b0, 1'b1, 8'(i), 1);

    // Reference points against literal values.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, ref_in[i], 2, 1, ref_out[i]);

    // Hold while addr toggles and valid_in is low.
    step(1'b0, 1'b1, 8'h01, 3, 1, 8'h7c);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'hff, 3, 1, 8'h7c);

    // Back-to-back.
    step(1'b0, 1'b1, 8'h00, 4, 1, 8'h63);
    step(1'b0, 1'b1, 8'h53, 4, 1, 8'hed);
    step(1'b0, 1'b1, 8'hff, 4, 1, 8'h16);

    // One-cycle reset inside a valid stream of 0x20.
    step(1'b0, 1'b1, 8'h20, 5, 1, 8'hb7);
    step(1'b1, 1'b1, 8'h20, 5, 1, 8'h00);
    step(1'b0, 1'b1, 8'h20, 5, 1, 8'hb7);

    // Random addr and valid_in.
    for (int i = 0; i < 1024; i++) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 6);

    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
